// File: rtl/pipe_cpu_core.sv
// Three-stage (FD / EM / WB) pipelined core for the 10-bit ISA with a parametrised datapath,
// handshaked data-memory port, branch squash in EM and a retired-instruction counter.
module pipe_cpu_core #(
    parameter int DATA_W = 10,
    parameter int PC_W   = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [9:0]        imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              cpu_halted,
    output logic [CNT_W-1:0]  retired_count
);

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_SHF   = 3'b001;
    localparam logic [2:0] OP_BNE   = 3'b010;
    localparam logic [2:0] OP_ADDI  = 3'b011;
    localparam logic [2:0] OP_JUMP  = 3'b100;
    localparam logic [2:0] OP_BEQ   = 3'b101;
    localparam logic [2:0] OP_LOAD  = 3'b110;
    localparam logic [2:0] OP_STORE = 3'b111;

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_next;
    logic [DATA_W-1:0] rf [8];

    // EM stage registers
    logic              em_valid;
    logic [9:0]        em_ins;
    logic [PC_W-1:0]   em_pc;
    logic [DATA_W-1:0] em_a;
    logic [DATA_W-1:0] em_b;

    // WB stage registers
    logic              wb_valid;
    logic              wb_we;
    logic [2:0]        wb_dst;
    logic [DATA_W-1:0] wb_data;

    // FD: decode and register read with write-through from WB
    logic [2:0]        fd_op;
    logic [2:0]        fd_rs_idx;
    logic [2:0]        fd_rt_idx;
    logic [DATA_W-1:0] fd_a;
    logic [DATA_W-1:0] fd_b;
    logic              fd_jump;
    logic [PC_W-1:0]   fd_jump_target;

    assign fd_op          = imem_data[9:7];
    assign fd_rs_idx      = {imem_data[2], imem_data[6:5]};
    assign fd_rt_idx      = {imem_data[2], imem_data[4:3]};
    assign fd_a           = (wb_valid && wb_we && wb_dst == fd_rs_idx) ? wb_data : rf[fd_rs_idx];
    assign fd_b           = (wb_valid && wb_we && wb_dst == fd_rt_idx) ? wb_data : rf[fd_rt_idx];
    assign fd_jump        = (fd_op == OP_JUMP);
    assign fd_jump_target = PC_W'($signed(imem_data[6:0]));

    // EM: decode, operand forwarding from WB
    logic [2:0]        em_op;
    logic [1:0]        em_f;
    logic [2:0]        em_rs_idx;
    logic [2:0]        em_rt_idx;
    logic [DATA_W-1:0] a_fwd;
    logic [DATA_W-1:0] b_fwd;
    logic [DATA_W-1:0] eff_addr;
    logic              mem_op;
    logic              store_op;
    logic              stall;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic              em_halt;
    logic              fd_kill;
    logic [DATA_W-1:0] em_res;
    logic              em_wr;

    assign em_op     = em_ins[9:7];
    assign em_f      = em_ins[1:0];
    assign em_rs_idx = {em_ins[2], em_ins[6:5]};
    assign em_rt_idx = {em_ins[2], em_ins[4:3]};
    assign a_fwd     = (wb_valid && wb_we && wb_dst == em_rs_idx) ? wb_data : em_a;
    assign b_fwd     = (wb_valid && wb_we && wb_dst == em_rt_idx) ? wb_data : em_b;
    assign eff_addr  = a_fwd + DATA_W'(em_f);

    assign mem_op    = em_valid && (em_op == OP_LOAD || em_op == OP_STORE);
    assign store_op  = em_valid && (em_op == OP_STORE);
    assign stall     = mem_op && !dmem_ready;
    assign br_taken  = em_valid && ((em_op == OP_BEQ && a_fwd == b_fwd) ||
                                    (em_op == OP_BNE && a_fwd != b_fwd));
    assign br_target = em_pc + PC_W'(1) + PC_W'(em_f);
    assign em_halt   = em_valid && (em_op == OP_SHF) && (em_f == 2'b10);
    assign fd_kill   = br_taken || em_halt || cpu_halted;

    assign dmem_req   = mem_op;
    assign dmem_we    = store_op;
    assign dmem_addr  = mem_op ? eff_addr : '0;
    assign dmem_wdata = store_op ? b_fwd : '0;
    assign imem_addr  = pc;

    always_comb begin
        em_res = '0;
        em_wr  = 1'b0;
        case (em_op)
            OP_ALU: begin
                em_wr = 1'b1;
                case (em_f)
                    2'b00:   em_res = a_fwd + b_fwd;
                    2'b01:   em_res = a_fwd - b_fwd;
                    2'b10:   em_res = DATA_W'($signed(a_fwd) < $signed(b_fwd));
                    default: em_res = ~(a_fwd & b_fwd);
                endcase
            end
            OP_SHF: begin
                if (em_f == 2'b00) begin
                    em_res = a_fwd >> 1;
                    em_wr  = 1'b1;
                end else if (em_f == 2'b01) begin
                    em_res = a_fwd << 1;
                    em_wr  = 1'b1;
                end
            end
            OP_ADDI: begin
                em_res = a_fwd + DATA_W'($signed(em_f));
                em_wr  = 1'b1;
            end
            OP_LOAD: begin
                em_res = dmem_rdata;
                em_wr  = 1'b1;
            end
            default: begin
                em_res = '0;
                em_wr  = 1'b0;
            end
        endcase
    end

    // A taken branch outranks a JUMP sitting in FD behind it
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (stall || em_halt || cpu_halted) begin
            pc_next = pc;
        end else if (br_taken) begin
            pc_next = br_target;
        end else if (fd_jump) begin
            pc_next = fd_jump_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= '0;
            em_valid      <= 1'b0;
            em_ins        <= '0;
            em_pc         <= '0;
            em_a          <= '0;
            em_b          <= '0;
            wb_valid      <= 1'b0;
            wb_we         <= 1'b0;
            wb_dst        <= '0;
            wb_data       <= '0;
            cpu_halted    <= 1'b0;
            retired_count <= '0;
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else begin
            pc <= pc_next;

            // While stalled, capture the forwarded operands: the WB source disappears next cycle
            if (stall) begin
                em_a <= a_fwd;
                em_b <= b_fwd;
            end else if (fd_kill) begin
                em_valid <= 1'b0;
            end else begin
                em_valid <= 1'b1;
                em_ins   <= imem_data;
                em_pc    <= pc;
                em_a     <= fd_a;
                em_b     <= fd_b;
            end

            if (stall) begin
                wb_valid <= 1'b0;
                wb_we    <= 1'b0;
            end else begin
                wb_valid <= em_valid;
                wb_we    <= em_valid && em_wr;
                wb_dst   <= em_rt_idx;
                wb_data  <= em_res;
            end

            if (wb_valid && wb_we) begin
                rf[wb_dst] <= wb_data;
            end
            if (wb_valid) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            if (em_halt) begin
                cpu_halted <= 1'b1;
            end
        end
    end

endmodule
